// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the two-master memory arbiter: FSM state
//   encodings, the bus-owner encoding and the poison word returned to a
//   reader when the optional bus watchdog (MEM_ARB_TIMEOUT_EN) fires.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUS_IF = 2'd1,
    ST_BUS_D  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [31:0] POISON_WORD = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog
//   Counts bus cycles of the current transaction that pass without an
//   acknowledge and flags expiry on the cycle the count reaches TIMEOUT.
//   Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk_i, rst_i  clock and asynchronous active-high reset
//   active_i      arbiter is in a bus state this cycle
//   ack_i         bus acknowledge this cycle
//   expire_o      this is the TIMEOUT-th bus cycle without an ack
module mem_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count restarts whenever the arbiter leaves the bus states, so every
  // new transaction begins at zero without a separate clear strobe.
  always_comb begin
    cnt_d = '0;
    if (active_i && !ack_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack on the expiry cycle counts as a normal completion, so it masks expiry.
  assign expire_o = active_i && !ack_i && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates the instruction-fetch port and the data (load/store) port
//   onto one request/acknowledge memory bus. The data port has fixed
//   priority; each requester is held until its one-cycle ack pulse.
//   Optional bus watchdog: define MEM_ARB_TIMEOUT_EN.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   if_req_i/if_addr_i                fetch request and word address
//   if_rdata_o/if_ack_o               fetched word and completion pulse
//   d_req_i/d_we_i/d_addr_i/d_wdata_i data request, direction, address, data
//   d_rdata_o/d_ack_o                 load data and completion pulse
//   bus_cyc_o/bus_we_o/bus_addr_o/bus_wdata_o  bus request side
//   bus_rdata_i/bus_ack_i             bus response side
//   bus_err_o                         sticky watchdog timeout flag
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              bus_cyc_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;
  logic              in_bus;
  logic              timeout;

  assign in_bus = (state_q == ST_BUS_IF) || (state_q == ST_BUS_D);

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .active_i (in_bus),
    .ack_i    (bus_ack_i),
    .expire_o (timeout)
  );
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT;
  assign timeout = 1'b0;
`endif

  // Next-state logic. Every output is a register, so the value each output
  // should show in the coming cycle is decided here. Acks default low so
  // they can only ever be a single-cycle pulse during DONE.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      ST_IDLE: begin
        // Data wins so a stalled memory stage drains before fetch proceeds.
        if (d_req_i) begin
          state_d = ST_BUS_D;
          owner_d = OWN_D;
          cyc_d   = 1'b1;
          we_d    = d_we_i;
          addr_d  = d_addr_i;
          wdata_d = d_wdata_i;
        end else if (if_req_i) begin
          state_d = ST_BUS_IF;
          owner_d = OWN_IF;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = if_addr_i;
          wdata_d = '0;
        end
      end
      ST_BUS_IF, ST_BUS_D: begin
        if (bus_ack_i || timeout) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          if (!bus_ack_i) begin
            err_d = 1'b1;
          end
          if (owner_q == OWN_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus_ack_i ? bus_rdata_i : DATA_W'(POISON_WORD);
          end else begin
            d_ack_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = bus_ack_i ? bus_rdata_i : DATA_W'(POISON_WORD);
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction with no ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      err_q      <= err_d;
    end
  end

  assign bus_cyc_o   = cyc_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_ack_o     = d_ack_q;
  assign bus_err_o   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed and randomized bench for mem_arbiter. The bench plays both
//   requesters and the memory bus, and predicts results from the arbiter's
//   rules: data wins ties, each transaction ends with one ack pulse to its
//   owner, only reads update the owner's rdata, and (with
//   MEM_ARB_TIMEOUT_EN) a bus silent for TIMEOUT cycles returns a poison word.
module tb_mem_arbiter;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam int TB_TIMEOUT = 255;
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_ack_o;
  logic              bus_cyc_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_ack_i;
  logic              bus_err_o;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: what each rdata port and the error flag should hold.
  logic [DATA_W-1:0] expIfRdata = '0;
  logic [DATA_W-1:0] expDRdata  = '0;
  logic              expErr     = 1'b0;

  mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ack_o    (if_ack_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_rdata_o   (d_rdata_o),
    .d_ack_o     (d_ack_o),
    .bus_cyc_o   (bus_cyc_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i),
    .bus_err_o   (bus_err_o)
  );

  // Free-running 10 ns clock; the DUT acts on rising edges, the bench on falling ones.
  always #5 clk_i = ~clk_i;

  // Hard stop in case a transaction never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "[TB] simulation timeout");
  end

  // Compare one observation with its prediction and count the result.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive both requester ports (blocking, from the falling edge).
  task automatic applyStimulus(input bit dReq, input bit dWe, input logic [ADDR_W-1:0] dAddr,
                               input logic [DATA_W-1:0] dWdata, input bit ifReq,
                               input logic [ADDR_W-1:0] ifAddr);
    d_req_i   = dReq;
    d_we_i    = dWe;
    d_addr_i  = dAddr;
    d_wdata_i = dWdata;
    if_req_i  = ifReq;
    if_addr_i = ifAddr;
  endtask

  // Every output is checked against its idle value.
  task automatic checkIdle(input string tag);
    checkOutput({tag, "_cyc"}, 64'(bus_cyc_o), 64'd0);
    checkOutput({tag, "_ifack"}, 64'(if_ack_o), 64'd0);
    checkOutput({tag, "_dack"}, 64'(d_ack_o), 64'd0);
    checkOutput({tag, "_ifrdata"}, 64'(if_rdata_o), 64'(expIfRdata));
    checkOutput({tag, "_drdata"}, 64'(d_rdata_o), 64'(expDRdata));
    checkOutput({tag, "_err"}, 64'(bus_err_o), 64'(expErr));
  endtask

  // Play the bus for the transaction the arbiter should grant at the next
  // rising edge, then check the DONE pulse and the return to IDLE. Called
  // from the falling edge of an IDLE cycle with the requests already driven.
  task automatic serveOne(input string tag, input bit isData, input bit we,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                          input int waits, input logic [DATA_W-1:0] rdata);
    bit timedOut;
    int lastCycle;
    timedOut  = TIMEOUT_EN && (waits >= TB_TIMEOUT);
    lastCycle = timedOut ? TB_TIMEOUT - 1 : waits;
    @(posedge clk_i);
    for (int i = 0; i <= lastCycle; i++) begin
      @(negedge clk_i);
      checkOutput({tag, "_bus_cyc"}, 64'(bus_cyc_o), 64'd1);
      checkOutput({tag, "_bus_we"}, 64'(bus_we_o), 64'(we));
      checkOutput({tag, "_bus_addr"}, 64'(bus_addr_o), 64'(addr));
      if (we) checkOutput({tag, "_bus_wdata"}, 64'(bus_wdata_o), 64'(wdata));
      checkOutput({tag, "_early_ack"}, 64'({if_ack_o, d_ack_o}), 64'd0);
      bus_ack_i   = (i == waits) && !timedOut;
      bus_rdata_i = (i == waits) ? rdata : $urandom;
      @(posedge clk_i);
    end
    @(negedge clk_i);
    bus_ack_i   = 1'b0;
    bus_rdata_i = $urandom;
    if (timedOut) expErr = 1'b1;
    if (isData && !we) expDRdata = timedOut ? 32'hDEADBEEF : rdata;
    if (!isData) expIfRdata = timedOut ? 32'hDEADBEEF : rdata;
    checkOutput({tag, "_done_cyc"}, 64'(bus_cyc_o), 64'd0);
    checkOutput({tag, "_done_ifack"}, 64'(if_ack_o), 64'(!isData));
    checkOutput({tag, "_done_dack"}, 64'(d_ack_o), 64'(isData));
    checkOutput({tag, "_done_ifrdata"}, 64'(if_rdata_o), 64'(expIfRdata));
    checkOutput({tag, "_done_drdata"}, 64'(d_rdata_o), 64'(expDRdata));
    checkOutput({tag, "_done_err"}, 64'(bus_err_o), 64'(expErr));
    // The owner has seen its ack and withdraws its request.
    if (isData) d_req_i = 1'b0;
    else if_req_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput({tag, "_after_acks"}, 64'({if_ack_o, d_ack_o}), 64'd0);
    checkOutput({tag, "_after_cyc"}, 64'(bus_cyc_o), 64'd0);
  endtask

  initial begin
    logic [ADDR_W-1:0] rAddrD, rAddrI;
    logic [DATA_W-1:0] rWdata;
    bit rDReq, rIfReq, rWe;
    int pattern;

    rst_i       = 1'b1;
    bus_ack_i   = 1'b0;
    bus_rdata_i = '0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0);
    #1;
    checkIdle("reset");
    checkOutput("reset_we", 64'(bus_we_o), 64'd0);
    checkOutput("reset_addr", 64'(bus_addr_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkIdle("post_reset");

    // Fetch, zero wait states.
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 30'h10);
    serveOne("fetch0", 1'b0, 1'b0, 30'h10, '0, 0, 32'h12345678);

    // Both requests together: data load first, then the waiting fetch.
    applyStimulus(1'b1, 1'b0, 30'h20, '0, 1'b1, 30'h4);
    serveOne("both_data", 1'b1, 1'b0, 30'h20, '0, 3, 32'hA5A5_0020);
    serveOne("both_fetch", 1'b0, 1'b0, 30'h4, '0, 0, 32'h0000_0004);

    // Store leaves the load data untouched.
    applyStimulus(1'b1, 1'b1, 30'h8, 32'hCAFEF00D, 1'b0, '0);
    serveOne("store", 1'b1, 1'b1, 30'h8, 32'hCAFEF00D, 1, 32'h1111_2222);

    // Bus ack while idle is ignored.
    bus_ack_i   = 1'b1;
    bus_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    checkIdle("stray_ack");
    @(negedge clk_i);
    checkIdle("stray_ack2");

`ifdef MEM_ARB_TIMEOUT_EN
    // A load the bus never answers times out with poison data.
    applyStimulus(1'b1, 1'b0, 30'h30, '0, 1'b0, '0);
    serveOne("timeout", 1'b1, 1'b0, 30'h30, '0, 1000, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 30'h31);
    serveOne("after_timeout", 1'b0, 1'b0, 30'h31, '0, 1, 32'h7777_0031);
`endif

    // Randomized traffic from either or both ports.
    for (int n = 0; n < 40; n++) begin
      pattern = $urandom_range(1, 3);
      rDReq   = pattern[0];
      rIfReq  = pattern[1];
      rWe     = $urandom_range(0, 1) == 1;
      rAddrD  = ADDR_W'($urandom);
      rAddrI  = ADDR_W'($urandom);
      rWdata  = $urandom;
      applyStimulus(rDReq, rWe, rAddrD, rWdata, rIfReq, rAddrI);
      if (rDReq) serveOne("rand_data", 1'b1, rWe, rAddrD, rWdata, $urandom_range(0, 6), $urandom);
      if (rIfReq) serveOne("rand_fetch", 1'b0, 1'b0, rAddrI, '0, $urandom_range(0, 6), $urandom);
    end

    // Reset in the middle of a read: everything clears at once, no ack.
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 30'h55);
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("midreset_cyc_before", 64'(bus_cyc_o), 64'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i    = 1'b1;
    if_req_i = 1'b0;
    expIfRdata = '0;
    expDRdata  = '0;
    expErr     = 1'b0;
    #1;
    checkIdle("midreset");
    checkOutput("midreset_addr", 64'(bus_addr_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    checkIdle("midreset_release");
    @(negedge clk_i);
    checkIdle("midreset_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
